// File: rtl/tv_sequencer.sv
// ============================================================================
// Module      : tv_sequencer
// Description : Clocked test-vector sequencer that drives a combinational DUT
//               from a loadable vector memory and counts output mismatches.
//               Optional macro TV_STOP_ON_FAIL_EN ends a run at the first fail.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tv_sequencer #(
    parameter int N_IN   = 3,
    parameter int N_OUT  = 1,
    parameter int DEPTH  = 8,
    parameter int SETTLE = 1,
    parameter int CNT_W  = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       tv_we,
    input  logic [$clog2(DEPTH)-1:0]   tv_addr,
    input  logic [N_IN+N_OUT-1:0]      tv_wdata,
    input  logic [$clog2(DEPTH):0]     num_vec,
    input  logic                       start,
    input  logic [N_OUT-1:0]           dut_out,
    output logic [N_IN-1:0]            dut_in,
    output logic                       busy,
    output logic                       done,
    output logic                       mismatch,
    output logic [CNT_W-1:0]           err_count,
    output logic [$clog2(DEPTH)-1:0]   fail_idx
);

    localparam int c_AW = $clog2(DEPTH);
    localparam int c_VW = N_IN + N_OUT;
    localparam int c_WW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETTLE = 2'd1,
        S_CHECK  = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    state_t             r_state;
    logic [c_VW-1:0]    r_mem [DEPTH];
    logic [c_AW-1:0]    r_idx;
    logic [c_AW:0]      r_num_vec;
    logic [c_WW-1:0]    r_wait_cnt;
    logic [N_IN-1:0]    r_dut_in;
    logic               r_busy;
    logic               r_done;
    logic               r_mismatch;
    logic [CNT_W-1:0]   r_err_count;
    logic [c_AW-1:0]    r_fail_idx;

    logic               w_idle;
    logic [c_AW:0]      w_num_clamped;
    logic [c_VW-1:0]    w_cur;
    logic [c_AW-1:0]    w_next_idx;
    logic [c_VW-1:0]    w_next;
    logic               w_fail;
    logic               w_last;

    assign w_idle        = (r_state == S_IDLE) || (r_state == S_DONE);
    assign w_num_clamped = (num_vec > (c_AW+1)'(DEPTH)) ? (c_AW+1)'(DEPTH) : num_vec;
    assign w_cur         = r_mem[r_idx];
    // Wraps only when idx is the final entry, where w_last ends the run first.
    assign w_next_idx    = r_idx + c_AW'(1);
    assign w_next        = r_mem[w_next_idx];
    assign w_fail        = (dut_out != w_cur[N_OUT-1:0]);
    assign w_last        = ({1'b0, r_idx} == (r_num_vec - (c_AW+1)'(1)));

    // Vector memory is not reset so contents survive a reset.
    always_ff @(posedge clk) begin
        if (tv_we && w_idle) begin
            r_mem[tv_addr] <= tv_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_idx       <= '0;
            r_num_vec   <= '0;
            r_wait_cnt  <= '0;
            r_dut_in    <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_mismatch  <= 1'b0;
            r_err_count <= '0;
            r_fail_idx  <= '0;
        end else begin
            r_mismatch <= 1'b0;
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        r_err_count <= '0;
                        r_fail_idx  <= '0;
                        r_num_vec   <= w_num_clamped;
                        if (w_num_clamped == '0) begin
                            r_state <= S_DONE;
                            r_done  <= 1'b1;
                        end else begin
                            r_idx      <= '0;
                            r_dut_in   <= r_mem[0][c_VW-1:N_OUT];
                            r_wait_cnt <= '0;
                            r_state    <= S_SETTLE;
                            r_busy     <= 1'b1;
                            r_done     <= 1'b0;
                        end
                    end
                end
                S_SETTLE: begin
                    r_wait_cnt <= r_wait_cnt + c_WW'(1);
                    if (r_wait_cnt == c_WW'(SETTLE - 1)) begin
                        r_state <= S_CHECK;
                    end
                end
                S_CHECK: begin
                    if (w_fail) begin
                        r_mismatch <= 1'b1;
                        r_fail_idx <= r_idx;
                        if (~&r_err_count) begin
                            r_err_count <= r_err_count + CNT_W'(1);
                        end
                    end
`ifdef TV_STOP_ON_FAIL_EN
                    if (w_last || w_fail) begin
`else
                    if (w_last) begin
`endif
                        r_state <= S_DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end else begin
                        r_idx      <= w_next_idx;
                        r_dut_in   <= w_next[c_VW-1:N_OUT];
                        r_wait_cnt <= '0;
                        r_state    <= S_SETTLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign dut_in    = r_dut_in;
    assign busy      = r_busy;
    assign done      = r_done;
    assign mismatch  = r_mismatch;
    assign err_count = r_err_count;
    assign fail_idx  = r_fail_idx;

endmodule

`default_nettype wire

// File: tb/tb_tv_sequencer.sv
// ============================================================================
// Module      : tb_tv_sequencer
// Description : Testbench for tv_sequencer driving a 3-input sillyfunction.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_tv_sequencer;

    logic       clk = 1'b0;
    logic       reset;
    logic       tv_we;
    logic [2:0] tv_addr;
    logic [3:0] tv_wdata;
    logic [3:0] num_vec;
    logic       start;
    logic [0:0] dut_out;
    logic [2:0] dut_in;
    logic       busy;
    logic       done;
    logic       mismatch;
    logic [7:0] err_count;
    logic [2:0] fail_idx;

    int         n_checks = 0;
    int         n_errors = 0;
    logic       exp_bit [8];
    logic [2:0] last_dut_in;

    always #5 clk = ~clk;

    tv_sequencer #(
        .N_IN   (3),
        .N_OUT  (1),
        .DEPTH  (8),
        .SETTLE (1),
        .CNT_W  (8)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .tv_we     (tv_we),
        .tv_addr   (tv_addr),
        .tv_wdata  (tv_wdata),
        .num_vec   (num_vec),
        .start     (start),
        .dut_out   (dut_out),
        .dut_in    (dut_in),
        .busy      (busy),
        .done      (done),
        .mismatch  (mismatch),
        .err_count (err_count),
        .fail_idx  (fail_idx)
    );

    function automatic logic ref_y(input logic [2:0] v);
        logic a, b, c;
        a = v[2];
        b = v[1];
        c = v[0];
        return (~b & ~c) | (a & ~b);
    endfunction

    assign dut_out = ref_y(dut_in);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic is_bad(input int j);
        return exp_bit[j] != ref_y(3'(j));
    endfunction

    task automatic load_mem(input logic [7:0] corrupt);
        for (int i = 0; i < 8; i++) begin
            exp_bit[i] = ref_y(3'(i)) ^ corrupt[i];
            tv_we      = 1'b1;
            tv_addr    = 3'(i);
            tv_wdata   = {3'(i), exp_bit[i]};
            step();
        end
        tv_we = 1'b0;
    endtask

    task automatic run(input logic [3:0] nv, input bit poke);
        int   n;
        int   n_run;
        int   errs;
        int   fidx;
        bit   seen;
        logic exp_mm;
        n     = (nv > 4'd8) ? 8 : int'(nv);
        n_run = n;
        errs  = 0;
        fidx  = 0;
        seen  = 1'b0;
        for (int i = 0; i < n; i++) begin
            if (is_bad(i) && !seen) begin
                errs++;
                fidx = i;
`ifdef TV_STOP_ON_FAIL_EN
                seen  = 1'b1;
                n_run = i + 1;
`endif
            end
        end
        num_vec = nv;
        start   = 1'b1;
        step();
        start   = 1'b0;
        for (int k = 0; k <= 2 * n_run; k++) begin
            chk("busy", busy, 32'(k < 2 * n_run));
            chk("done", done, 32'(k >= 2 * n_run));
            exp_mm = 1'b0;
            if (k >= 2 && (k % 2) == 0) exp_mm = is_bad(k / 2 - 1);
            chk("mismatch", mismatch, exp_mm);
            if (k < 2 * n_run) chk("dut_in_step", dut_in, k / 2);
            if (poke && k == 3) begin
                start    = 1'b1;
                tv_we    = 1'b1;
                tv_addr  = 3'd0;
                tv_wdata = 4'b0000;
            end
            if (poke && k == 4) begin
                start = 1'b0;
                tv_we = 1'b0;
            end
            if (k < 2 * n_run) step();
        end
        chk("err_count", err_count, errs);
        chk("fail_idx", fail_idx, fidx);
        if (n_run > 0) last_dut_in = 3'(n_run - 1);
        chk("dut_in_final", dut_in, last_dut_in);
    endtask

    initial begin
        reset    = 1'b1;
        tv_we    = 1'b0;
        tv_addr  = '0;
        tv_wdata = '0;
        num_vec  = '0;
        start    = 1'b0;
        last_dut_in = 3'd0;
        step();
        step();
        chk("rst_dut_in", dut_in, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_mismatch", mismatch, 0);
        chk("rst_err_count", err_count, 0);
        chk("rst_fail_idx", fail_idx, 0);
        reset = 1'b0;
        step();

        // Clean run over all eight vectors
        load_mem(8'h00);
        run(4'd8, 1'b0);

        // Single fault at entry 3
        load_mem(8'b0000_1000);
        run(4'd8, 1'b0);

        // Faults at entries 2 and 6
        load_mem(8'b0100_0100);
        run(4'd8, 1'b0);

        // Zero-length run and clamped over-length run
        load_mem(8'h00);
        run(4'd0, 1'b0);
        run(4'd12, 1'b0);

        // Write and start while busy are both ignored; rerun shows entry 0 intact
        run(4'd8, 1'b1);
        run(4'd8, 1'b0);

        // Reset in the middle of vector 4
        load_mem(8'b0010_0001);
        num_vec = 4'd8;
        start   = 1'b1;
        step();
        start   = 1'b0;
        repeat (8) step();
        chk("mid_dut_in", dut_in, 4);
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("abort_busy", busy, 0);
        chk("abort_dut_in", dut_in, 0);
        chk("abort_err_count", err_count, 0);
        chk("abort_done", done, 0);
        last_dut_in = 3'd0;
        run(4'd8, 1'b0);

        // Randomized corruption masks and run lengths
        for (int r = 0; r < 8; r++) begin
            load_mem(8'($urandom));
            run(4'($urandom_range(0, 15)), 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/tv_sequencer.md
Name: tv_sequencer

Overview:
- Synthesizable test-vector sequencer that sits directly upstream of a small combinational DUT (e.g. the 3-input sillyfunction).
- Holds a loadable vector memory. Each entry packs the DUT inputs and the expected DUT outputs.
- On start, it drives each vector's inputs to the DUT, waits a settle time, samples and compares the DUT output, and counts mismatches.
- Replaces hand-written delay-based stimulus with a clocked, self-checking stage usable in simulation and on FPGA.

Parameters:
- N_IN, 3, DUT input width.
- N_OUT, 1, DUT output width.
- DEPTH, 8, number of vector entries. Power of 2, ≥2.
- SETTLE, 1, cycles between driving dut_in and the compare. Must be ≥1.
- CNT_W, 8, width of err_count.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- tv_we  in  1  vector memory write enable.
- tv_addr  in  $clog2(DEPTH)  write address.
- tv_wdata  in  N_IN+N_OUT  entry: [N_IN+N_OUT-1:N_OUT] = inputs, [N_OUT-1:0] = expected.
- num_vec  in  $clog2(DEPTH)+1  vectors to run. Sampled at start; values >DEPTH are clamped to DEPTH.
- start  in  1  run request, level-sampled in IDLE/DONE.
- dut_out  in  N_OUT  DUT response.
- dut_in  out  N_IN  registered DUT stimulus.
- busy  out  1  high in SETTLE and CHECK.
- done  out  1  high in DONE.
- mismatch  out  1  one-cycle pulse per failing vector.
- err_count  out  CNT_W  saturating mismatch count.
- fail_idx  out  $clog2(DEPTH)  index of most recent failing vector.

Behaviour:
- Reset: state = IDLE. dut_in, busy, done, mismatch, err_count, fail_idx, idx and wait_cnt all clear to 0. Memory contents are not reset and are retained.
- States: IDLE, SETTLE, CHECK, DONE.
- IDLE/DONE with start = 1:
  - Clear err_count and fail_idx; latch the clamped num_vec.
  - If num_vec = 0: go to DONE with err_count = 0.
  - Otherwise: idx ← 0, dut_in ← mem[0] inputs, wait_cnt ← 0, go to SETTLE.
- SETTLE: wait_cnt increments. When wait_cnt = SETTLE-1, go to CHECK.
- CHECK: compare dut_out with mem[idx] expected.
  - On inequality, at the next edge: mismatch = 1 for one cycle, err_count += 1 (saturating at all-ones), fail_idx ← idx.
  - If idx = num_vec-1: go to DONE.
  - Otherwise: idx += 1, dut_in ← mem[idx+1] inputs, wait_cnt ← 0, go to SETTLE.
- Cost per vector: SETTLE+1 cycles. Total run time is num_vec·(SETTLE+1) cycles from the start edge to done = 1.
- DONE: done = 1. dut_in, err_count and fail_idx hold until the next start or reset.
- Memory write: on any edge with tv_we = 1, in IDLE or DONE only. Writes while busy are ignored. Reads are combinational from the internal register array.
- start while busy: ignored.
- Reset mid-run: aborts the run immediately on that edge; all outputs return to reset values.
- idx never wraps: the run terminates at num_vec-1.

Optional Feature:
- Macro: TV_STOP_ON_FAIL_EN.
- Defined: the first mismatch in CHECK sends the FSM straight to DONE. err_count = 1, and fail_idx holds that index. The remaining vectors are not applied.
- Undefined: all num_vec vectors always run and every mismatch is counted.

Test Plan:
All scenarios use N_IN = 3, N_OUT = 1, SETTLE = 1, with a reference model y = (~b&~c)|(a&~b) in the bench driving dut_out.
- Clean run: load 8 correct vectors (expected bits 1,0,0,0,1,1,0,0 for abc = 000..111), num_vec = 8, pulse start → dut_in steps 0..7 every 2 cycles; done = 1 exactly 16 cycles after the start edge; err_count = 0; mismatch never asserts.
- Single fault: corrupt entry 3 expected to 1 → exactly one mismatch pulse, err_count = 1, fail_idx = 3.
- Multiple faults: corrupt entries 2 and 6 → err_count = 2, fail_idx = 6. With TV_STOP_ON_FAIL_EN defined: DONE after vector 2, err_count = 1, fail_idx = 2, dut_in = 3'b010.
- Boundaries: num_vec = 0 → done on the cycle after start, err_count = 0. num_vec = 12 → clamped, runs 8 vectors.
- Ignored/aborted operations:
  - tv_we to entry 0 while busy → memory unchanged.
  - start while busy → no restart.
  - reset at vector 4 → busy = 0, dut_in = 0, err_count = 0 next cycle.
  - A following start reruns all 8 vectors from index 0.
